four_bit_adder_ec: RTL and testbench

- Registered carry-look-ahead adder: two unsigned WIDTH-bit operands in, WIDTH+1-bit sum (carry-out is the MSB) out.
- Default WIDTH=4 is the classic 4-bit CLA.
- Sits in the datapath as a single-cycle arithmetic unit with a valid qualifier.
- Carry chain is flat look-ahead, never ripple.

---
 rtl/four_bit_adder_ec_pkg.sv | 31 +++
 rtl/four_bit_adder_ec_cla_block4.sv | 33 +++
 rtl/four_bit_adder_ec.sv | 112 +++++++++++
 tb/tb_four_bit_adder_ec.sv | 132 +++++++++++++
 4 files changed

// File: rtl/four_bit_adder_ec_pkg.sv
// Shared constants and look-ahead helpers for the registered CLA adder.
package four_bit_adder_ec_pkg;

    localparam int unsigned GROUP_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } grp_gp_t;

    // Group generate/propagate of a 4-bit slice, flat sum-of-products.
    function automatic grp_gp_t cla_group_gp(input logic [3:0] g, input logic [3:0] p);
        grp_gp_t r;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.p = p[3] & p[2] & p[1] & p[0];
        return r;
    endfunction

    // Look-ahead carries {c4, c3, c2, c1}; each term uses only g/p/cin, never a prior carry.
    function automatic logic [3:0] cla_carries(input logic [3:0] g, input logic [3:0] p,
                                               input logic cin);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/four_bit_adder_ec_cla_block4.sv
// Combinational 4-bit carry-look-ahead slice with group G/P outputs.
module cla_block4
    import four_bit_adder_ec_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       g_o,
    output logic       p_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    grp_gp_t    gp;
    logic       unused_c4;

    // Per-bit g/p, look-ahead carries and sum bits.
    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        c     = cla_carries(g, p, cin_i);
        sum_o = p ^ {c[2:0], cin_i};
        gp    = cla_group_gp(g, p);
        g_o   = gp.g;
        p_o   = gp.p;
    end

    // The slice carry-out leaves through G/P; the second level rebuilds it.
    assign unused_c4 = c[3];

endmodule

// File: rtl/four_bit_adder_ec.sv
// Registered carry-look-ahead adder, 1-cycle latency, WIDTH in {4, 8, 16}.
// Optional signed-overflow output enabled by defining FOUR_BIT_ADDER_EC_OVF_EN.
module four_bit_adder_ec
    import four_bit_adder_ec_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH:0]   SUM
`ifdef FOUR_BIT_ADDER_EC_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NumGroups = WIDTH / GROUP_W;

    logic [WIDTH-1:0]     sum_bits;
    logic [NumGroups-1:0] grp_g_raw;
    logic [NumGroups-1:0] grp_p_raw;
    logic [3:0]           grp_g;
    logic [3:0]           grp_p;
    logic [3:0]           lac;
    logic [NumGroups:0]   grp_c;
    logic                 carry_out;
    logic                 unused_lac;

    logic [WIDTH:0] sum_d, sum_q;
    logic           valid_d, valid_q;

    for (genvar k = 0; k < NumGroups; k++) begin : gen_grp
        cla_block4 u_cla (
            .a_i   (A[k*GROUP_W +: GROUP_W]),
            .b_i   (B[k*GROUP_W +: GROUP_W]),
            .cin_i (grp_c[k]),
            .sum_o (sum_bits[k*GROUP_W +: GROUP_W]),
            .g_o   (grp_g_raw[k]),
            .p_o   (grp_p_raw[k])
        );
    end

    // Second-level look-ahead: group carry-ins from padded group G/P, carry-in 0.
    always_comb begin
        grp_g                  = '0;
        grp_p                  = '0;
        grp_g[NumGroups-1:0]   = grp_g_raw;
        grp_p[NumGroups-1:0]   = grp_p_raw;
        lac                    = cla_carries(grp_g, grp_p, 1'b0);
        grp_c                  = '0;
        for (int k = 1; k <= NumGroups; k++) begin
            grp_c[k] = lac[k-1];
        end
        carry_out = grp_c[NumGroups];
    end

    // Carries above the top group are padding only.
    assign unused_lac = ^lac;

    // Capture a new result only when qualified, so idle operands never reach SUM.
    always_comb begin
        sum_d   = sum_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d = {carry_out, sum_bits};
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign SUM       = sum_q;
    assign out_valid = valid_q;

`ifdef FOUR_BIT_ADDER_EC_OVF_EN
    logic ovf_d, ovf_q;
    logic c_msb_in;

    // Carry into the MSB recovered from s = p ^ c; overflow is c_W ^ c_(W-1).
    always_comb begin
        c_msb_in = sum_bits[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1];
        ovf_d    = ovf_q;
        if (in_valid) begin
            ovf_d = carry_out ^ c_msb_in;
        end
    end

    // Overflow flag registered alongside SUM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_adder_ec.sv
// Directed self-checking bench for four_bit_adder_ec (WIDTH=4).
module tb_four_bit_adder_ec;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [4:0] sum;
`ifdef FOUR_BIT_ADDER_EC_OVF_EN
    logic       ovf;
`endif

    int checks;
    int failures;

    four_bit_adder_ec #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .SUM       (sum)
`ifdef FOUR_BIT_ADDER_EC_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held with valid max operands: nothing may be captured.
        rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF;
        tick();
        check_eq("rst1_sum", {27'd0, sum}, 32'd0);
        check_eq("rst1_valid", {31'd0, out_valid}, 32'd0);
`ifdef FOUR_BIT_ADDER_EC_OVF_EN
        check_eq("rst1_ovf", {31'd0, ovf}, 32'd0);
`endif
        tick();
        check_eq("rst2_sum", {27'd0, sum}, 32'd0);
        check_eq("rst2_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_sum", {27'd0, sum}, 32'd30);
        check_eq("rel_valid", {31'd0, out_valid}, 32'd1);

        // Exhaustive operand sweep, one result per cycle.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            a = v[7:4];
            b = v[3:0];
            tick();
            check_eq("sweep_sum", {27'd0, sum}, 32'(v[7:4]) + 32'(v[3:0]));
            check_eq("sweep_valid", {31'd0, out_valid}, 32'd1);
        end

        // Directed corner values.
        a = 4'd0;  b = 4'd0;  tick(); check_eq("zero", {27'd0, sum}, 32'd0);
        a = 4'd15; b = 4'd0;  tick(); check_eq("f_plus_0", {27'd0, sum}, 32'd15);
        a = 4'd8;  b = 4'd8;  tick(); check_eq("8_plus_8", {27'd0, sum}, 32'd16);
        a = 4'd15; b = 4'd15; tick(); check_eq("max", {27'd0, sum}, 32'd30);

        // Carry propagation through the group.
        a = 4'b0111; b = 4'b0001; tick(); check_eq("prop3", {27'd0, sum}, 32'd8);
        a = 4'b1111; b = 4'b0001; tick(); check_eq("prop4", {27'd0, sum}, 32'd16);

        // Hold: idle cycles keep SUM and drop out_valid.
        a = 4'd9; b = 4'd6; tick();
        check_eq("hold_cap", {27'd0, sum}, 32'd15);
        in_valid = 1'b0; a = 4'd3; b = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_sum", {27'd0, sum}, 32'd15);
            check_eq("hold_valid", {31'd0, out_valid}, 32'd0);
        end

        // Mid-stream reset discards the 5+5 in flight.
        in_valid = 1'b1; a = 4'd5; b = 4'd5; rst_n = 1'b0;
        tick();
        check_eq("mrst_sum", {27'd0, sum}, 32'd0);
        check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check_eq("mrst_after_sum", {27'd0, sum}, 32'd0);
        check_eq("mrst_after_valid", {31'd0, out_valid}, 32'd0);

`ifdef FOUR_BIT_ADDER_EC_OVF_EN
        in_valid = 1'b1;
        a = 4'd7; b = 4'd1; tick();
        check_eq("ovf_7_1", {31'd0, ovf}, 32'd1);
        check_eq("ovf_7_1_sum", {27'd0, sum}, 32'd8);
        a = 4'd8; b = 4'd8; tick();
        check_eq("ovf_8_8", {31'd0, ovf}, 32'd1);
        check_eq("ovf_8_8_sum", {27'd0, sum}, 32'd16);
        a = 4'd15; b = 4'd1; tick();
        check_eq("ovf_f_1", {31'd0, ovf}, 32'd0);
        check_eq("ovf_f_1_sum", {27'd0, sum}, 32'd16);
        a = 4'd7; b = 4'd1; tick();
        in_valid = 1'b0; a = 4'd1; b = 4'd1; tick();
        check_eq("ovf_hold", {31'd0, ovf}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
